// File: rtl/ffs_pkg.sv
// Constants shared by the find-first-set pipeline and its inverse decoder,
// so both blocks stay width-matched.
package ffs_pkg;
    localparam int FFS_IDX_W  = 10;
    localparam int FFS_VEC_W  = 1 << FFS_IDX_W;
    localparam int FFS_STAGES = FFS_IDX_W;
endpackage

// File: rtl/ffs_dec_stage.sv
// One decoder pipeline stage: doubles the partial one-hot using the top residual
// index bit. FFS_DEC_THERMO_EN adds a below-index mask built the same way.
module ffs_dec_stage
    import ffs_pkg::*;
#(
    parameter int IDX_W = FFS_IDX_W,
    parameter int STAGE = 0
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 en,
    input  logic                                                 in_valid,
    input  logic                                                 in_zero,
    input  logic [(1<<STAGE)-1:0]                                in_vec,
    input  logic [IDX_W-STAGE-1:0]                               in_idx,
`ifdef FFS_DEC_THERMO_EN
    input  logic [(1<<STAGE)-1:0]                                in_thermo,
    output logic [(2<<STAGE)-1:0]                                out_thermo,
`endif
    output logic                                                 out_valid,
    output logic                                                 out_zero,
    output logic [(2<<STAGE)-1:0]                                out_vec,
    output logic [((IDX_W-STAGE-1 > 0) ? IDX_W-STAGE-1 : 1)-1:0] out_idx
);
    localparam int IN_W  = 1 << STAGE;
    localparam int RW    = IDX_W - STAGE - 1;
    localparam int RES_W = (RW > 0) ? RW : 1;

    logic              sel;
    logic [2*IN_W-1:0] vec_d;
    logic [RES_W-1:0]  idx_d;

    assign sel = in_idx[IDX_W-STAGE-1];

    // Bit j of the narrower vector splits into the pair {2j+1, 2j}.
    always_comb begin
        vec_d = '0;
        for (int j = 0; j < IN_W; j++) begin
            vec_d[2*j+1] = in_vec[j] & sel;
            vec_d[2*j]   = in_vec[j] & ~sel;
        end
    end

    generate
        if (RW > 0) begin : g_res
            assign idx_d = in_idx[RES_W-1:0];
        end else begin : g_nores
            assign idx_d = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_zero  <= 1'b0;
            out_vec   <= '0;
            out_idx   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_zero  <= in_zero;
            out_vec   <= vec_d;
            out_idx   <= idx_d;
        end
    end

`ifdef FFS_DEC_THERMO_EN
    logic [2*IN_W-1:0] thermo_d;

    // Lower half of a pair lies below the index when the index sits in the upper half.
    always_comb begin
        thermo_d = '0;
        for (int j = 0; j < IN_W; j++) begin
            thermo_d[2*j+1] = in_thermo[j];
            thermo_d[2*j]   = in_thermo[j] | (in_vec[j] & sel);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_thermo <= '0;
        end else if (en) begin
            out_thermo <= thermo_d;
        end
    end
`endif
endmodule

// File: rtl/ffs_index_decoder.sv
// Pipelined index -> one-hot decoder, one index bit per stage (IDX_W stages).
// Optional out_thermo (below-index mask) is enabled by FFS_DEC_THERMO_EN.
module ffs_index_decoder
    import ffs_pkg::*;
#(
    parameter  int IDX_W = FFS_IDX_W,
    localparam int VEC_W = 1 << IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] out_vec
`ifdef FFS_DEC_THERMO_EN
    ,
    output logic [VEC_W-1:0] out_thermo
`endif
);
    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high. The whole pipe freezes only while out_valid is held without out_ready;
    // bubbles never stall and are never squeezed out.
    logic stall;
    logic advance;
    logic idx_tail_unused;

    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = advance;

    generate
        for (genvar s = 0; s < IDX_W; s++) begin : g_stage
            localparam int RES_W = (IDX_W - s - 1 > 0) ? IDX_W - s - 1 : 1;

            logic                 prev_valid;
            logic                 prev_zero;
            logic [(1<<s)-1:0]    prev_vec;
            logic [IDX_W-s-1:0]   prev_idx;
            logic                 valid;
            logic                 zero;
            logic [(2<<s)-1:0]    vec;
            logic [RES_W-1:0]     idx;
`ifdef FFS_DEC_THERMO_EN
            logic [(1<<s)-1:0]    prev_thermo;
            logic [(2<<s)-1:0]    thermo;
`endif

            if (s == 0) begin : g_head
                assign prev_valid = in_valid;
                assign prev_zero  = in_zero;
                assign prev_vec   = 1'b1;
                assign prev_idx   = in_idx;
`ifdef FFS_DEC_THERMO_EN
                assign prev_thermo = 1'b0;
`endif
            end else begin : g_tail
                assign prev_valid = g_stage[s-1].valid;
                assign prev_zero  = g_stage[s-1].zero;
                assign prev_vec   = g_stage[s-1].vec;
                assign prev_idx   = g_stage[s-1].idx;
`ifdef FFS_DEC_THERMO_EN
                assign prev_thermo = g_stage[s-1].thermo;
`endif
            end

            ffs_dec_stage #(
                .IDX_W(IDX_W),
                .STAGE(s)
            ) u_stage (
                .clk       (clk),
                .reset     (reset),
                .en        (advance),
                .in_valid  (prev_valid),
                .in_zero   (prev_zero),
                .in_vec    (prev_vec),
                .in_idx    (prev_idx),
`ifdef FFS_DEC_THERMO_EN
                .in_thermo (prev_thermo),
                .out_thermo(thermo),
`endif
                .out_valid (valid),
                .out_zero  (zero),
                .out_vec   (vec),
                .out_idx   (idx)
            );
        end
    endgenerate

    // The last stage has no residual index bits left; its constant-zero index bit is unused.
    assign idx_tail_unused = g_stage[IDX_W-1].idx[0];

    assign out_valid = g_stage[IDX_W-1].valid;
    assign out_vec   = g_stage[IDX_W-1].vec & {VEC_W{~g_stage[IDX_W-1].zero}};
`ifdef FFS_DEC_THERMO_EN
    assign out_thermo = g_stage[IDX_W-1].thermo & {VEC_W{~g_stage[IDX_W-1].zero}};
`endif
endmodule

// File: tb/tb_ffs_index_decoder.sv
// Self-checking bench for ffs_index_decoder; thermo checks follow FFS_DEC_THERMO_EN.
module tb_ffs_index_decoder;
    localparam int IDX_W = 10;
    localparam int VEC_W = 1 << IDX_W;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic             in_zero;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] out_vec;
`ifdef FFS_DEC_THERMO_EN
    logic [VEC_W-1:0] out_thermo;
`endif

    logic [IDX_W:0] exp_q[$];
    int tests;
    int fails;

    ffs_index_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_idx   (in_idx),
        .in_zero  (in_zero),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_vec  (out_vec)
`ifdef FFS_DEC_THERMO_EN
        ,
        .out_thermo(out_thermo)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // Entry = {zero_flag, idx}; result is bit idx set, or nothing when zero_flag.
    function automatic logic [VEC_W-1:0] model_onehot(input logic [IDX_W:0] e);
        logic [VEC_W-1:0] r;
        r = '0;
        if (!e[IDX_W]) r[e[IDX_W-1:0]] = 1'b1;
        return r;
    endfunction

    function automatic logic [VEC_W-1:0] model_thermo(input logic [IDX_W:0] e);
        logic [VEC_W-1:0] r;
        r = '0;
        if (!e[IDX_W])
            for (int n = 0; n < int'(e[IDX_W-1:0]); n++) r[n] = 1'b1;
        return r;
    endfunction

    function automatic int first_bit(input logic [VEC_W-1:0] v);
        for (int i = 0; i < VEC_W; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- driver ----------------
    // Called at posedge+1 with inputs already set; samples handshake, advances one clock.
    task automatic tick(output logic acc, output logic ret,
                        output logic [VEC_W-1:0] rv, output logic [VEC_W-1:0] rt);
        logic [IDX_W:0] ent;
        #1;
        acc = in_valid & in_ready;
        ret = out_valid & out_ready;
        ent = {in_zero, in_idx};
        rv  = out_vec;
`ifdef FFS_DEC_THERMO_EN
        rt  = out_thermo;
`else
        rt  = '0;
`endif
        @(posedge clk);
        #1;
        if (acc) exp_q.push_back(ent);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_idx = '0; in_zero = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        tests++; if (out_vec !== '0) begin fails++; $display("FAIL reset_vec: got first=%0d want -1", first_bit(out_vec)); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        logic acc, ret;
        logic [VEC_W-1:0] rv, rt;
        int cnt;
        in_valid = 1'b1; in_idx = 10'd4; in_zero = 1'b0;
        tick(acc, ret, rv, rt);
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 30) begin
            tick(acc, ret, rv, rt);
            cnt++;
        end
        tests++; if (cnt != 10) begin fails++; $display("FAIL latency: got %0d clocks want 10", cnt); end
        tests++; if (out_vec !== model_onehot({1'b0, 10'd4})) begin
            fails++; $display("FAIL latency_vec: got first=%0d ones=%0d want first=4 ones=1", first_bit(out_vec), $countones(out_vec));
        end
        tick(acc, ret, rv, rt);
        if (ret && exp_q.size() > 0) void'(exp_q.pop_front());
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_drop: got %b want 0", out_valid); end
        exp_q.delete();
    endtask

    // Streams a list of entries back-to-back, then drains and checks every retirement.
    task automatic test_stream(input string name, input logic [IDX_W:0] ents[$]);
        logic acc, ret;
        logic [VEC_W-1:0] rv, rt;
        logic [IDX_W:0] e;
        int first_cyc, last_cyc, nret, cyc;
        first_cyc = -1; last_cyc = -1; nret = 0; cyc = 0;
        foreach (ents[k]) begin
            in_valid = 1'b1; {in_zero, in_idx} = ents[k];
            tick(acc, ret, rv, rt);
            cyc++;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            tick(acc, ret, rv, rt);
            cyc++;
            if (ret) begin
                e = exp_q.pop_front();
                nret++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                tests++;
                if (rv !== model_onehot(e)) begin
                    fails++; $display("FAIL %s_vec: got first=%0d ones=%0d want first=%0d ones=%0d", name,
                                      first_bit(rv), $countones(rv), first_bit(model_onehot(e)), $countones(model_onehot(e)));
                end
`ifdef FFS_DEC_THERMO_EN
                tests++;
                if (rt !== model_thermo(e)) begin
                    fails++; $display("FAIL %s_thermo: got ones=%0d want ones=%0d", name, $countones(rt), $countones(model_thermo(e)));
                end
`endif
            end
        end
        tests++; if (nret != ents.size()) begin fails++; $display("FAIL %s_count: got %0d want %0d", name, nret, ents.size()); end
        tests++; if (last_cyc - first_cyc != ents.size() - 1) begin
            fails++; $display("FAIL %s_spacing: got span %0d want %0d", name, last_cyc - first_cyc, ents.size() - 1);
        end
    endtask

    task automatic test_boundaries();
        logic [IDX_W:0] ents[$];
        ents = '{{1'b0, 10'd0}, {1'b0, 10'd1023}, {1'b1, 10'd4}};
        test_stream("boundary", ents);
    endtask

    task automatic test_back_to_back();
        logic [IDX_W:0] ents[$];
        for (int i = 0; i < 10; i++) ents.push_back({1'b0, IDX_W'(i)});
        test_stream("b2b", ents);
    endtask

    task automatic test_thermo();
        logic [IDX_W:0] ents[$];
        ents = '{{1'b0, 10'd4}, {1'b0, 10'd0}, {1'b0, 10'd513}};
        test_stream("thermo", ents);
    endtask

    task automatic test_backpressure();
        logic acc, ret;
        logic [VEC_W-1:0] rv, rt;
        logic [IDX_W:0] e;
        int nret;
        nret = 0;
        foreach (exp_q[k]) exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_zero = 1'b0; in_idx = IDX_W'(3 + 2 * i);
            tick(acc, ret, rv, rt);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 30 && !out_valid; c++) tick(acc, ret, rv, rt);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready: got %b want 0", in_ready); end
            tests++; if (out_valid !== 1'b1 || out_vec !== model_onehot({1'b0, 10'd3})) begin
                fails++; $display("FAIL bp_hold: got valid=%b first=%0d want valid=1 first=3", out_valid, first_bit(out_vec));
            end
            tick(acc, ret, rv, rt);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            tick(acc, ret, rv, rt);
            if (ret) begin
                e = exp_q.pop_front();
                nret++;
                tests++;
                if (rv !== model_onehot(e)) begin
                    fails++; $display("FAIL bp_order: got first=%0d want first=%0d", first_bit(rv), first_bit(model_onehot(e)));
                end
            end
        end
        tests++; if (nret != 3) begin fails++; $display("FAIL bp_count: got %0d want 3", nret); end
    endtask

    task automatic test_random();
        logic acc, ret;
        logic [VEC_W-1:0] rv, rt;
        logic [IDX_W:0] e;
        exp_q.delete();
        acc = 1'b1;
        for (int c = 0; c < 400 || (exp_q.size() > 0 && c < 600); c++) begin
            // a pending, unaccepted input is held until it is taken
            if (acc || !in_valid) begin
                in_valid = (c < 400) && ($urandom_range(0, 9) < 7);
                in_idx   = IDX_W'($urandom_range(0, VEC_W - 1));
                in_zero  = ($urandom_range(0, 9) == 0);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            tick(acc, ret, rv, rt);
            if (ret) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL rand_extra: got first=%0d with empty expectation", first_bit(rv));
                end else begin
                    e = exp_q.pop_front();
                    if (rv !== model_onehot(e)) begin
                        fails++; $display("FAIL rand_vec: got first=%0d ones=%0d want first=%0d ones=%0d",
                                          first_bit(rv), $countones(rv), first_bit(model_onehot(e)), $countones(model_onehot(e)));
                    end
`ifdef FFS_DEC_THERMO_EN
                    tests++;
                    if (rt !== model_thermo(e)) begin
                        fails++; $display("FAIL rand_thermo: got ones=%0d want ones=%0d", $countones(rt), $countones(model_thermo(e)));
                    end
`endif
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL rand_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        logic acc, ret;
        logic [VEC_W-1:0] rv, rt;
        logic seen;
        exp_q.delete();
        in_valid = 1'b1; in_idx = 10'd100; in_zero = 1'b0;
        tick(acc, ret, rv, rt);
        in_valid = 1'b0;
        repeat (4) tick(acc, ret, rv, rt);
        #2 reset = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || out_vec !== '0) begin
            fails++; $display("FAIL mid_reset_clear: got valid=%b first=%0d want valid=0 first=-1", out_valid, first_bit(out_vec));
        end
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick(acc, ret, rv, rt);
            seen = seen | out_valid;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL mid_reset_ghost: got out_valid=1 want 0"); end

        // reset while a result is held under backpressure clears it without a clock edge
        in_valid = 1'b1; in_idx = 10'd7;
        tick(acc, ret, rv, rt);
        in_valid = 1'b0;
        for (int c = 0; c < 30 && !out_valid; c++) tick(acc, ret, rv, rt);
        out_ready = 1'b0;
        tick(acc, ret, rv, rt);
        tests++; if (out_valid !== 1'b1 || out_vec !== model_onehot({1'b0, 10'd7})) begin
            fails++; $display("FAIL stall_hold: got valid=%b first=%0d want valid=1 first=7", out_valid, first_bit(out_vec));
        end
        #2 reset = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || out_vec !== '0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL stall_reset: got valid=%b first=%0d ready=%b want 0 -1 1", out_valid, first_bit(out_vec), in_ready);
        end
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_latency();
        test_boundaries();
        test_back_to_back();
        test_thermo();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
